// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared datapath width and FETCH/HOLD state encoding for the fetch unit
package if_fetch_unit_pkg;
   localparam int WORD_LEN = 32;
   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, load and bubble controls
//   clk, rst (sync, active-low) | load: capture inst_d/pc_d as valid | bubble: clear (wins over load)
//   inst, pc, valid: registered IF/ID contents; with neither control asserted they hold
module if_id_reg #(
   parameter int WORD_LEN = if_fetch_unit_pkg::WORD_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                bubble,
   input  logic [WORD_LEN-1:0] inst_d,
   input  logic [WORD_LEN-1:0] pc_d,
   output logic [WORD_LEN-1:0] inst,
   output logic [WORD_LEN-1:0] pc,
   output logic                valid
);
   always_ff @(posedge clk)
      if (!rst || bubble) begin
         inst  <= '0;
         pc    <= '0;
         valid <= 1'b0;
      end else if (load) begin
         inst  <= inst_d;
         pc    <= pc_d;
         valid <= 1'b1;
      end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with PC, FETCH/HOLD FSM and a one-entry skid buffer
//   clk, rst (sync, active-low) | freeze: ID stall | br_taken/br_offset: ID redirect (word offset)
//   imem_req/imem_addr: fetch request at PC | imem_ready/imem_rdata: memory response
//   inst_id/pc_id/valid_id: IF/ID register outputs (pc_id = fetch address + 4)
module if_fetch_unit #(
   parameter int                      WORD_LEN = if_fetch_unit_pkg::WORD_LEN,
   parameter logic [WORD_LEN-1:0]     RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                br_taken,
   input  logic [WORD_LEN-1:0] br_offset,
   output logic                imem_req,
   output logic [WORD_LEN-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [WORD_LEN-1:0] imem_rdata,
   output logic [WORD_LEN-1:0] inst_id,
   output logic [WORD_LEN-1:0] pc_id,
   output logic                valid_id
);
   import if_fetch_unit_pkg::*;
   fetch_state_t        state, state_nx;
   logic [WORD_LEN-1:0] pc, pc_nx, pc_inc, buf_inst, buf_pc;
   logic                buf_load, load, bubble;
   assign pc_inc    = pc + WORD_LEN'(4);
   assign imem_addr = pc;
   assign imem_req  = rst && state == FETCH;
   always_comb begin
      pc_nx    = pc;
      state_nx = state;
      buf_load = 1'b0;
      load     = 1'b0;
      bubble   = 1'b0;
      if (freeze) begin
         // a word returning during a stall is parked so it is neither lost nor refetched
         buf_load = state == FETCH && imem_ready;
         state_nx = buf_load ? HOLD : state;
      end else if (br_taken) begin
         pc_nx    = pc_id + (br_offset << 2);
         state_nx = FETCH;
         bubble   = 1'b1;
      end else if (state == HOLD) begin
         pc_nx    = pc_inc;
         state_nx = FETCH;
         load     = 1'b1;
      end else begin
         pc_nx  = imem_ready ? pc_inc : pc;
         load   = imem_ready;
         bubble = !imem_ready;
      end
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         buf_inst <= '0;
         buf_pc   <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (buf_load) begin
            buf_inst <= imem_rdata;
            buf_pc   <= pc_inc;
         end
      end
   if_id_reg #(.WORD_LEN(WORD_LEN)) u_if_id (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .bubble(bubble),
      .inst_d(state == HOLD ? buf_inst : imem_rdata),
      .pc_d  (state == HOLD ? buf_pc : pc_inc),
      .inst  (inst_id),
      .pc    (pc_id),
      .valid (valid_id)
   );
endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter: WORD_LEN, default 32, data and address width.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 Port: freeze  in  1  hazard stall from the ID stage.
REQ-006 Port: br_taken  in  1  branch taken, resolved in ID.
REQ-007 Port: br_offset  in  WORD_LEN  signed word offset from ID.
REQ-008 Port: imem_req  out  1  fetch request to instruction memory.
REQ-009 Port: imem_addr  out  WORD_LEN  byte address of the fetch (= PC).
REQ-010 Port: imem_ready  in  1  imem_rdata valid for the current imem_addr.
REQ-011 Port: imem_rdata  in  WORD_LEN  fetched instruction word.
REQ-012 Port: inst_id  out  WORD_LEN  IF/ID instruction.
REQ-013 Port: pc_id  out  WORD_LEN  IF/ID PC: fetch address + 4.
REQ-014 Port: valid_id  out  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-015 States: FETCH (imem_req=1) and HOLD (fetched word parked in a 1-entry skid buffer, imem_req=0).
REQ-016 imem_addr shall equal the PC register at all times; the memory tolerates the address changing while imem_ready=0.
REQ-017 Priority in every state: freeze over br_taken over normal flow.
REQ-018 freeze=1: PC, inst_id, pc_id and valid_id hold; br_taken is ignored.
REQ-019 FETCH, freeze=1, imem_ready=1: capture imem_rdata with PC+4 into the skid buffer; go to HOLD; PC holds.
REQ-020 freeze=0, br_taken=1, any state: PC <= pc_id + (br_offset << 2), modulo 2^32.
REQ-021 Same case as REQ-020: the in-flight or buffered word is discarded, IF/ID is loaded with a bubble (valid_id=0, inst_id=0, pc_id=0), and the state returns to FETCH.
REQ-022 FETCH, freeze=0, br_taken=0, imem_ready=1: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4.
REQ-023 FETCH, freeze=0, br_taken=0, imem_ready=0: IF/ID gets a bubble; PC holds.
REQ-024 HOLD, freeze=0, br_taken=0: IF/ID <= buffer contents with valid=1; PC <= PC+4; go to FETCH. The same-cycle fetch is not issued.
REQ-025 PC increments by 4 and wraps 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-026 Instruction latency: the word appears on inst_id the cycle after the edge that samples imem_ready=1, when not frozen.
REQ-027 No instruction is duplicated or lost across freeze, except the words discarded per REQ-021.

Reset
REQ-028 While rst=0 at an edge: PC=RESET_PC, state=FETCH, skid buffer empty, inst_id=0, pc_id=0, valid_id=0.
REQ-029 imem_req shall be forced to 0 combinationally while rst=0.
REQ-030 Reset mid-operation, including in HOLD or during a pending request, shall discard all in-flight data.
REQ-031 The first request after reset release uses imem_addr=RESET_PC.

Structure
REQ-032 WORD_LEN and the FETCH/HOLD state encoding shall live in the shared defines/package; RESET_PC stays a module parameter.
REQ-033 The IF/ID register with load/bubble/hold controls shall be a sub-module, if_id_reg; the PC, FSM and skid buffer stay in if_fetch_unit.

Verification
REQ-034 Reset release, imem_ready=1 every cycle, words A,B,C -> valid_id=1 with inst_id A,B,C and pc_id 4,8,12 on consecutive cycles.
REQ-035 freeze=1 for 3 cycles while imem_ready=1 on word at PC=8 -> IF/ID holds, imem_req=0 during HOLD; after release inst_id=word@8, pc_id=12, then fetch at 12; nothing is duplicated.
REQ-036 br_taken=1 with pc_id=16, br_offset=-2 -> next imem_addr=8 and one bubble (valid_id=0); the word fetched that cycle never reaches inst_id.
REQ-037 br_taken=1 and freeze=1 in the same cycle -> no redirect, PC holds; br_taken with freeze=0 a cycle later -> redirect.
REQ-038 imem_ready low for 2 cycles at PC=20 -> two bubbles, imem_addr stays 20, then the word appears with pc_id=24.
REQ-039 rst=0 asserted while in HOLD, then RESET_PC=32'h100 at release -> all outputs 0 and the buffered word dropped; first imem_addr=32'h100. PC=32'hFFFF_FFFC with a fetch -> next imem_addr=0.
